// File: rtl/spi_pkg.sv
// Shared SPI link definitions: receiver/transmitter state encoding and common constants.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    localparam int unsigned DEFAULT_WORD_WIDTH = 16;
    localparam int unsigned SYNC_DEPTH         = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, plus one delay flop
// to produce single-cycle rise/fall pulses in the CLK domain.
module spi_sync_edge #(
    parameter int unsigned DEPTH     = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic ASYNC_IN,
    output logic LEVEL,
    output logic RISE,
    output logic FALL
);

    logic [DEPTH-1:0] sync_q;
    logic             dly_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= {DEPTH{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], ASYNC_IN};
            dly_q  <= sync_q[DEPTH-1];
        end
    end

    assign LEVEL = sync_q[DEPTH-1];
    assign RISE  = LEVEL & ~dly_q;
    assign FALL  = ~LEVEL & dly_q;

endmodule

// File: rtl/spi_word_receiver.sv
// SPI slave receive path: oversamples SCLK/CS/DATA_IN in the CLK domain, assembles
// words and hands them to a single-entry valid/ready holding register.
module spi_word_receiver
    import spi_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  SCLK,
    input  logic                  CS,
    input  logic                  DATA_IN,
    output logic [WORD_WIDTH-1:0] WORD_DATA,
    output logic                  WORD_VALID,
    input  logic                  WORD_READY,
    output logic                  FRAME_ERR,
    output logic                  OVERRUN
);

    localparam int unsigned CNT_W = $clog2(WORD_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic unused_sync;

    spi_sync_edge #(.DEPTH(SYNC_DEPTH), .RESET_VAL(1'b0)) u_sclk_sync (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ASYNC_IN (SCLK),
        .LEVEL    (sclk_level),
        .RISE     (sclk_rise),
        .FALL     (sclk_fall)
    );

    spi_sync_edge #(.DEPTH(SYNC_DEPTH), .RESET_VAL(1'b1)) u_cs_sync (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ASYNC_IN (CS),
        .LEVEL    (cs_level),
        .RISE     (cs_rise),
        .FALL     (cs_fall)
    );

    assign unused_sync = ^{sclk_level, sclk_fall, cs_level};

    // Same depth as the SCLK path so the synced data lines up with sclk_rise.
    logic [SYNC_DEPTH-1:0] data_sync_q;
    logic                  data_s;

    assign data_s = data_sync_q[SYNC_DEPTH-1];

    spi_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d, shifted;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  word_done, consume;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        word_done   = 1'b0;
        frame_err_d = 1'b0;
        shifted     = LSB_FIRST ? {data_s, shift_q[WORD_WIDTH-1:1]}
                                : {shift_q[WORD_WIDTH-2:0], data_s};
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            ACTIVE: begin
                // A CS rise takes priority over a coincident SCLK rise.
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = (cnt_q != '0);
                    cnt_d       = '0;
                end else if (sclk_rise) begin
                    shift_d = shifted;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d     = '0;
                        word_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign consume = valid_q & WORD_READY;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (word_done) begin
            if (!valid_q || consume) begin
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            data_sync_q <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            data_sync_q <= {data_sync_q[SYNC_DEPTH-2:0], DATA_IN};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign WORD_DATA  = data_q;
    assign WORD_VALID = valid_q;
    assign FRAME_ERR  = frame_err_q;
    assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_spi_word_receiver.sv
// Bench for spi_word_receiver: an LSB-first and an MSB-first instance share one SPI bus.
module tb_spi_word_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        din = 1'b0;
    logic        ready = 1'b1;
    logic [15:0] data_a, data_b;
    logic        valid_a, valid_b, ferr_a, ferr_b, ovr_a, ovr_b;

    always #5 clk = ~clk;

    spi_word_receiver #(.WORD_WIDTH(16), .LSB_FIRST(1'b1)) dut_lsb (
        .CLK        (clk),
        .RST_N      (rst_n),
        .SCLK       (sclk),
        .CS         (cs),
        .DATA_IN    (din),
        .WORD_DATA  (data_a),
        .WORD_VALID (valid_a),
        .WORD_READY (ready),
        .FRAME_ERR  (ferr_a),
        .OVERRUN    (ovr_a)
    );

    spi_word_receiver #(.WORD_WIDTH(16), .LSB_FIRST(1'b0)) dut_msb (
        .CLK        (clk),
        .RST_N      (rst_n),
        .SCLK       (sclk),
        .CS         (cs),
        .DATA_IN    (din),
        .WORD_DATA  (data_b),
        .WORD_VALID (valid_b),
        .WORD_READY (ready),
        .FRAME_ERR  (ferr_b),
        .OVERRUN    (ovr_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_t0  = 0;
    int first_valid_cyc = -1;
    int valid_cyc_a = 0;
    int ferr_cnt_a = 0, ferr_cnt_b = 0, ovr_cnt_a = 0, ovr_cnt_b = 0;
    logic [15:0] got_a[$];
    logic [15:0] got_b[$];
    logic        valid_a_prev = 1'b0, ready_prev = 1'b0;
    logic [15:0] data_a_prev = 16'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Consumer / pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (valid_a && ready) got_a.push_back(data_a);
        if (valid_b && ready) got_b.push_back(data_b);
        if (ferr_a) ferr_cnt_a++;
        if (ferr_b) ferr_cnt_b++;
        if (ovr_a) ovr_cnt_a++;
        if (ovr_b) ovr_cnt_b++;
        if (valid_a) valid_cyc_a++;
        if (valid_a && !valid_a_prev) first_valid_cyc = cyc;
        if (valid_a && valid_a_prev && !ready_prev) check("hold_stable", {16'h0, data_a}, {16'h0, data_a_prev});
        valid_a_prev = valid_a;
        ready_prev   = ready;
        data_a_prev  = data_a;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] rev16(logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    function automatic logic [31:0] at_a(int i);
        return (i < got_a.size()) ? {16'h0, got_a[i]} : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] at_b(int i);
        return (i < got_b.size()) ? {16'h0, got_b[i]} : 32'hFFFF_FFFF;
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // SCLK = CLK/8: 4 cycles low with data set up, 4 cycles high.
    task automatic send_bit(logic b);
        sclk = 1'b0;
        din  = b;
        step(4);
        sclk    = 1'b1;
        last_t0 = cyc + 1;
        step(4);
    endtask

    task automatic send_bits(logic [15:0] v, int n, bit lsb_order);
        for (int i = 0; i < n; i++) send_bit(lsb_order ? v[i] : v[15-i]);
    endtask

    task automatic cs_start();
        sclk = 1'b0;
        cs   = 1'b0;
        step(4);
    endtask

    task automatic cs_end();
        sclk = 1'b0;
        step(4);
        cs = 1'b1;
        step(8);
    endtask

    task automatic clear_obs();
        got_a.delete();
        got_b.delete();
    endtask

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        int          nwords;
        int          tail;
        logic [15:0] tail_val;
        int          exp_beats;
        int          exp_ferr;
        logic [15:0] exp0;
        logic [15:0] exp1;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int fa, fb, oa, ob;
        int exp_ferr_tot;
        logic [15:0] exp_q[$];

        vecs[0] = '{16'h0F0F, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0F0F, 16'h0000};
        vecs[1] = '{16'h335A, 16'h1234, 2, 0, 16'h0000, 2, 0, 16'h335A, 16'h1234};
        vecs[2] = '{16'h0000, 16'h0000, 0, 9, 16'h01FF, 0, 1, 16'h0000, 16'h0000};
        vecs[3] = '{16'hA5A5, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'hA5A5, 16'h0000};
        vecs[4] = '{16'hFFFF, 16'h0001, 2, 5, 16'h0015, 2, 1, 16'hFFFF, 16'h0001};

        // Reset state
        step(3);
        check("rst_data", {16'h0, data_a}, 32'h0);
        check("rst_valid", {31'h0, valid_a}, 32'h0);
        check("rst_ferr", {31'h0, ferr_a}, 32'h0);
        check("rst_ovr", {31'h0, ovr_a}, 32'h0);
        rst_n = 1'b1;
        step(4);

        // Latency: WORD_VALID 2 cycles after the last capture edge, high one cycle.
        clear_obs();
        valid_cyc_a = 0;
        first_valid_cyc = -1;
        cs_start();
        send_bits(16'h0F0F, 16, 1'b1);
        cs_end();
        check("lat_first_valid", first_valid_cyc, last_t0 + 2);
        check("lat_valid_width", valid_cyc_a, 1);
        check("lat_data", at_a(0), 32'h0F0F);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            clear_obs();
            fa = ferr_cnt_a; fb = ferr_cnt_b; oa = ovr_cnt_a; ob = ovr_cnt_b;
            cs_start();
            if (vecs[v].nwords >= 1) send_bits(vecs[v].w0, 16, 1'b1);
            if (vecs[v].nwords >= 2) send_bits(vecs[v].w1, 16, 1'b1);
            if (vecs[v].tail > 0) send_bits(vecs[v].tail_val, vecs[v].tail, 1'b1);
            cs_end();
            check($sformatf("vec%0d_beats_a", v), got_a.size(), vecs[v].exp_beats);
            check($sformatf("vec%0d_beats_b", v), got_b.size(), vecs[v].exp_beats);
            check($sformatf("vec%0d_ferr_a", v), ferr_cnt_a - fa, vecs[v].exp_ferr);
            check($sformatf("vec%0d_ferr_b", v), ferr_cnt_b - fb, vecs[v].exp_ferr);
            check($sformatf("vec%0d_ovr", v), (ovr_cnt_a - oa) + (ovr_cnt_b - ob), 0);
            if (vecs[v].exp_beats >= 1) begin
                check($sformatf("vec%0d_w0_a", v), at_a(0), {16'h0, vecs[v].exp0});
                check($sformatf("vec%0d_w0_b", v), at_b(0), {16'h0, rev16(vecs[v].exp0)});
            end
            if (vecs[v].exp_beats >= 2) begin
                check($sformatf("vec%0d_w1_a", v), at_a(1), {16'h0, vecs[v].exp1});
                check($sformatf("vec%0d_w1_b", v), at_b(1), {16'h0, rev16(vecs[v].exp1)});
            end
        end

        // Overrun: READY low, two words; first held, second dropped.
        clear_obs();
        oa = ovr_cnt_a; ob = ovr_cnt_b;
        ready = 1'b0;
        cs_start();
        send_bits(16'hAAAA, 16, 1'b1);
        send_bits(16'h5555, 16, 1'b1);
        cs_end();
        check("ovr_valid", {31'h0, valid_a}, 32'h1);
        check("ovr_held_a", {16'h0, data_a}, 32'hAAAA);
        check("ovr_held_b", {16'h0, data_b}, 32'h5555);
        check("ovr_pulse_a", ovr_cnt_a - oa, 1);
        check("ovr_pulse_b", ovr_cnt_b - ob, 1);
        ready = 1'b1;
        step(1);
        check("ovr_drain_valid", {31'h0, valid_a}, 32'h0);
        check("ovr_drain_cnt", got_a.size(), 1);
        check("ovr_drain_word", at_a(0), 32'hAAAA);

        // SCLK toggling with CS high is ignored; the next frame is clean.
        clear_obs();
        fa = ferr_cnt_a;
        send_bits(16'hFFFF, 16, 1'b1);
        sclk = 1'b0;
        step(8);
        check("idle_sclk_beats", got_a.size(), 0);
        check("idle_sclk_ferr", ferr_cnt_a - fa, 0);
        cs_start();
        send_bits(16'hA5A5, 16, 1'b1);
        cs_end();
        check("post_idle_word", at_a(0), 32'hA5A5);

        // Reset mid-word, then a fresh frame.
        clear_obs();
        fa = ferr_cnt_a; oa = ovr_cnt_a;
        cs_start();
        send_bits(16'hFFFF, 7, 1'b1);
        rst_n = 1'b0;
        cs    = 1'b1;
        sclk  = 1'b0;
        step(1);
        check("mid_rst_data", {16'h0, data_a}, 32'h0);
        check("mid_rst_valid", {31'h0, valid_a}, 32'h0);
        check("mid_rst_pulses", {30'h0, ferr_a, ovr_a}, 32'h0);
        step(2);
        rst_n = 1'b1;
        step(4);
        cs_start();
        send_bits(16'hC3C3, 16, 1'b1);
        cs_end();
        check("post_rst_cnt", got_a.size(), 1);
        check("post_rst_word", at_a(0), 32'hC3C3);
        check("post_rst_ferr", ferr_cnt_a - fa, 0);
        check("post_rst_ovr", ovr_cnt_a - oa, 0);

        // MSB-first master
        clear_obs();
        cs_start();
        send_bits(16'h8001, 16, 1'b0);
        send_bits(16'h1234, 16, 1'b0);
        cs_end();
        check("msb_w0_b", at_b(0), 32'h8001);
        check("msb_w1_b", at_b(1), 32'h1234);
        check("msb_w0_a", at_a(0), 32'h8001);
        check("msb_w1_a", at_a(1), 32'h2C48);

        // Randomised frames against a word-queue reference model.
        clear_obs();
        exp_q.delete();
        exp_ferr_tot = 0;
        fa = ferr_cnt_a; oa = ovr_cnt_a;
        for (int f = 0; f < 12; f++) begin
            int nw, tail;
            logic [15:0] w;
            nw   = $urandom_range(1, 3);
            tail = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 15) : 0;
            cs_start();
            for (int k = 0; k < nw; k++) begin
                w = 16'($urandom);
                exp_q.push_back(w);
                send_bits(w, 16, 1'b1);
            end
            if (tail > 0) begin
                send_bits(16'($urandom), tail, 1'b1);
                exp_ferr_tot++;
            end
            cs_end();
        end
        check("rnd_cnt_a", got_a.size(), exp_q.size());
        check("rnd_cnt_b", got_b.size(), exp_q.size());
        check("rnd_ferr", ferr_cnt_a - fa, exp_ferr_tot);
        check("rnd_ovr", ovr_cnt_a - oa, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("rnd_word%0d_a", i), at_a(i), {16'h0, exp_q[i]});
            check($sformatf("rnd_word%0d_b", i), at_b(i), {16'h0, rev16(exp_q[i])});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_word_receiver.md
# spi_word_receiver

Receive side of the team's SPI link: captures serial words driven on SCLK/CS/DATA by an SPI master and presents them as parallel words on a valid/ready interface in the local CLK domain. All SPI inputs are asynchronous to CLK and are synchronised and edge-detected internally; SCLK is never used as a clock. The block sits between the external SPI pins and the sample buffer feeding the FFT datapath.

## Interface
- WORD_WIDTH, 16: bits per word; legal range 2..32.
- LSB_FIRST, 1: 1 = first received bit is bit 0; 0 = first received bit is bit WORD_WIDTH-1.
- CLK  input  1  system clock; all state on rising edge.
- RST_N  input  1  reset; asynchronous, active-low.
- SCLK  input  1  SPI clock from master, idle low; data sampled on its rising edge.
- CS  input  1  chip select, active-low; high = bus idle.
- DATA_IN  input  1  serial data from master; stable around each SCLK rise.
- WORD_DATA  output  WORD_WIDTH  received word; valid while WORD_VALID=1.
- WORD_VALID  output  1  holding register contains an unconsumed word.
- WORD_READY  input  1  consumer accepts word when WORD_VALID & WORD_READY at a CLK edge.
- FRAME_ERR  output  1  one-cycle pulse: CS deasserted with a partial word.
- OVERRUN  output  1  one-cycle pulse: word completed while holding register full and not being consumed; new word dropped.

## Operation
- Reset values: WORD_DATA=0, WORD_VALID=0, FRAME_ERR=0, OVERRUN=0; shift register, bit counter, synchronisers cleared (SCLK/CS sync flops reset to idle: SCLK=0, CS=1); state IDLE.
- SCLK, CS, DATA_IN each pass through 2-flop synchronisers; SCLK and CS also through one delay flop for edge detection. DATA_IN uses the same depth so it stays aligned with SCLK.
- States: IDLE (synced CS=1) and ACTIVE (synced CS=0).
  - IDLE -> ACTIVE on synced CS falling edge; bit counter cleared, shift register cleared.
  - ACTIVE -> IDLE on synced CS rising edge; if bit counter != 0, FRAME_ERR pulses and the partial word is discarded; if 0, no pulse.
- In ACTIVE, each synced SCLK rising edge shifts in synced DATA_IN (LSB_FIRST=1: shift right, insert at MSB; 0: shift left, insert at LSB) and increments the bit counter.
- When the counter reaches WORD_WIDTH: counter wraps to 0, completed word offered to the holding register. Multiple words per CS frame are allowed back-to-back.
- Holding register: loads when empty, or when the current word is consumed in the same cycle (WORD_VALID stays 1, no OVERRUN). Otherwise the new word is dropped, OVERRUN pulses, old word retained.
- SCLK edges while in IDLE are ignored. SCLK rise coincident with synced CS rise: CS wins, edge ignored.
- WORD_VALID clears on consumption when no new word loads that cycle.

## Timing
- CLK frequency at least 4x SCLK frequency; SCLK high and low phases each at least 2 CLK periods; DATA_IN stable at least 2 CLK periods before and 1 after each SCLK rise; CS low at least 2 CLK periods before first SCLK rise.
- Capture edge t0 = first CLK edge at which the SCLK pin is sampled high. Bit shifted at t2; for the last bit of a word WORD_VALID and WORD_DATA update at t2 (2-cycle latency).
- FRAME_ERR pulses at the CLK edge 2 cycles after the CS pin is first sampled high.
- WORD_DATA holds constant while WORD_VALID=1 and not consumed.
- RST_N low mid-word: all state cleared immediately; first word after reset release requires a fresh CS falling edge.

## Structure
- Package spi_pkg: state enum (IDLE, ACTIVE), default WORD_WIDTH constant, synchroniser depth constant (2); shared with the SPI transmitter.
- Sub-module spi_sync_edge: N-flop synchroniser plus delay flop, outputs synced level, rise and fall pulses; instantiated for SCLK and CS.

## Test plan
- SCLK=CLK/8, LSB-first, send 0x0F0F in one CS frame, READY=1 -> WORD_DATA=0x0F0F, WORD_VALID one cycle, exactly 2 cycles after last capture edge.
- One CS frame with 0x335A then 0x1234, READY=1 -> two valid beats in order, no FRAME_ERR/OVERRUN.
- READY=0, send 0xAAAA then 0x5555 -> WORD_DATA stays 0xAAAA, OVERRUN pulses once; raise READY -> 0xAAAA consumed, VALID drops.
- CS deasserted after 9 bits -> FRAME_ERR single pulse, no VALID; next frame 0xA5A5 received correctly; SCLK toggles with CS high -> no effect.
- RST_N low after 7 bits -> all outputs 0; after release, full frame 0xC3C3 received correctly.
- LSB_FIRST=0, master sends 0x8001 MSB-first -> WORD_DATA=0x8001.
